// File: rtl/shift_reg_burst.sv
// ---------------------------------------------------------------------------
// shift_reg_burst
//
// Parametrised shift register with seven single-cycle shift/rotate/load
// operations plus clear, a serial output, and a counted burst-shift engine
// that lets a serial link controller request N shifts with one command.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   en_i     clock enable; low stalls every register, counter and the FSM
//   mode_i   single-cycle operation applied while idle
//            (000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//             100 ROL, 101 ROR, 110 ASR, 111 CLEAR)
//   sin_i    serial input bit
//   par_i    parallel load data
//   start_i  burst request, sampled while idle with en_i high
//   dir_i    burst direction (0 left, 1 right), latched at start
//   cnt_i    number of burst shifts, latched at start and clamped to WIDTH
//   P        parallel register contents
//   sout_o   bit the next shift in the current direction will discard
//   busy_o   high while a burst is in progress
//   done_o   one-cycle pulse after a burst (or zero-length burst) completes
// ---------------------------------------------------------------------------
module shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] P,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state_q, state_next;
    logic [WIDTH-1:0] p_q, p_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [CNT_W-1:0] cnt_clamped;
    logic             dir_q, dir_next;
    logic             done_q, done_set;

    // A burst can never usefully shift more than the register width, so the
    // requested count is clamped before it is latched.
    always_comb begin
        cnt_clamped = (cnt_i > WIDTH_C) ? WIDTH_C : cnt_i;
    end

    // Next-state and datapath decode. Start takes priority over mode_i while
    // idle and leaves P untouched in its own cycle. During a burst mode_i and
    // start_i are ignored; the shift with one shift left returns to idle and
    // requests the done pulse. Any state that is not BURST behaves as IDLE.
    always_comb begin
        state_next = state_q;
        p_next     = p_q;
        cnt_next   = cnt_q;
        dir_next   = dir_q;
        done_set   = 1'b0;

        case (state_q)
            S_BURST: begin
                if (dir_q) begin
                    p_next = {sin_i, p_q[WIDTH-1:1]};
                end else begin
                    p_next = {p_q[WIDTH-2:0], sin_i};
                end
                cnt_next = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    dir_next = dir_i;
                    cnt_next = cnt_clamped;
                    if (cnt_clamped != '0) begin
                        state_next = S_BURST;
                    end else begin
                        state_next = S_IDLE;
                        done_set   = 1'b1;
                    end
                end else begin
                    state_next = S_IDLE;
                    case (mode_i)
                        M_HOLD:  p_next = p_q;
                        M_LOAD:  p_next = par_i;
                        M_SHL: begin
                            p_next   = {p_q[WIDTH-2:0], sin_i};
                            dir_next = 1'b0;
                        end
                        M_SHR: begin
                            p_next   = {sin_i, p_q[WIDTH-1:1]};
                            dir_next = 1'b1;
                        end
                        M_ROL: begin
                            p_next   = {p_q[WIDTH-2:0], p_q[WIDTH-1]};
                            dir_next = 1'b0;
                        end
                        M_ROR: begin
                            p_next   = {p_q[0], p_q[WIDTH-1:1]};
                            dir_next = 1'b1;
                        end
                        M_ASR: begin
                            p_next   = {p_q[WIDTH-1], p_q[WIDTH-1:1]};
                            dir_next = 1'b1;
                        end
                        M_CLEAR: p_next = '0;
                        default: p_next = p_q;
                    endcase
                end
            end
        endcase
    end

    // State registers. Everything except done advances only when enabled.
    // done is a one-cycle pulse: it is only ever set on an enabled edge, and
    // any edge after it was set drops it again, stalled or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (en_i) begin
                state_q <= state_next;
                p_q     <= p_next;
                cnt_q   <= cnt_next;
                dir_q   <= dir_next;
            end
            done_q <= en_i & done_set;
        end
    end

    // Serial output shows the bit that would fall off on the next shift in
    // the currently tracked direction.
    always_comb begin
        P      = p_q;
        sout_o = dir_q ? p_q[0] : p_q[WIDTH-1];
        busy_o = (state_q == S_BURST);
        done_o = done_q;
    end

endmodule

// File: doc/shift_reg_burst.md
Name: shift_reg_burst

Overview:
- Parametrised successor to the team's 8-bit shift register.
- Provides configurable width, seven shift/rotate/load operations plus clear, and a serial output.
- Adds a counted burst-shift engine (IDLE/BURST FSM, busy/done handshake) so a serial link controller can request N shifts with one command.
- Sits between the parallel datapath and serial I/O blocks.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the burst count input.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en_i  input  1  clock enable; low = stall (no register, counter or FSM change)
- mode_i  input  3  single-cycle operation, IDLE only: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR
- sin_i  input  1  serial input bit
- par_i  input  WIDTH  parallel load data
- start_i  input  1  burst request (sampled in IDLE with en_i high)
- dir_i  input  1  burst direction: 0 left, 1 right; latched at start
- cnt_i  input  CNT_W  number of burst shifts; latched at start
- P  output  WIDTH  parallel register contents
- sout_o  output  1  serial output bit
- busy_o  output  1  high while FSM is in BURST
- done_o  output  1  one-cycle pulse after a burst completes

Behaviour:
- Reset (async, rst=1): P=0, state=IDLE, counter=0, dir_q=0, busy_o=0, done_o=0. Asserting rst mid-burst aborts it immediately; no done pulse is issued.
- All state updates occur on posedge clk, and only when en_i=1. Exception: done_o clears to 0 on any clock edge where it was 1, regardless of en_i.
- IDLE, start_i=0: mode_i applied in one cycle.
  - HOLD: P unchanged.
  - LOAD: P=par_i.
  - SHL: P={P[WIDTH-2:0],sin_i}.
  - SHR: P={sin_i,P[WIDTH-1:1]}.
  - ROL: P={P[WIDTH-2:0],P[WIDTH-1]}.
  - ROR: P={P[0],P[WIDTH-1:1]}.
  - ASR: P={P[WIDTH-1],P[WIDTH-1:1]}.
  - CLEAR: P=0.
- IDLE, start_i=1: start has priority over mode_i, and P is unchanged in the start cycle.
  - Latch dir_q=dir_i and counter=min(cnt_i,WIDTH).
  - If the clamped count is nonzero, go to BURST. Otherwise stay in IDLE and pulse done_o next cycle.
- BURST: each enabled cycle performs one shift in dir_q (left = SHL form, right = SHR form, both using sin_i) and decrements the counter.
  - When the shift with counter=1 occurs, next state is IDLE and done_o=1 for the following cycle.
  - mode_i and start_i are ignored throughout BURST.
- Latency: a burst of N shifts accepted at cycle 0 gives busy_o=1 in cycles 1..N, shifts at the edges ending cycles 1..N, and done_o=1 in cycle N+1. Each stalled cycle (en_i=0) extends this by one.
- A start in the done_o cycle is accepted, since the FSM is already IDLE.
- dir_q tracking: also updated by IDLE ops. SHL/ROL set dir_q=0; SHR/ROR/ASR set dir_q=1; HOLD/LOAD/CLEAR leave it unchanged.
- sout_o is combinational: P[WIDTH-1] when dir_q=0, else P[0]. It shows the bit that the next shift in the current direction discards.
- busy_o = (state==BURST), decoded directly from the state register.
- No X propagation: an illegal state decodes to IDLE.

Test Plan:
- Reset: drive rst=1 asynchronously mid-cycle -> P=0x00, busy_o=0, done_o=0, sout_o=0 without waiting for a clock edge.
- Single-cycle ops, WIDTH=8, each starting from P=0xA5 after LOAD:
  - SHL, sin_i=1 -> 0x4B
  - SHR, sin_i=0 -> 0x52
  - ROL -> 0x4B
  - ROR -> 0xD2
  - ASR from 0x85 -> 0xC2
  - CLEAR -> 0x00
  - HOLD for 3 cycles -> 0xA5 held
- Burst right: LOAD 0xF0, then start_i=1, dir_i=1, cnt_i=4, sin_i=0 -> busy_o high exactly 4 cycles, P=0x0F, done_o high 1 cycle immediately after, sout_o=1.
- Burst with stall and clamp:
  - P=0x00, start dir_i=0, cnt_i=12, sin_i=1, en_i held low 2 cycles mid-burst -> 8 shifts, busy_o high 10 cycles, P=0xFF, then one done_o pulse.
  - mode_i=LOAD asserted during the burst -> ignored.
- Zero count and back-to-back:
  - start with cnt_i=0 -> busy_o stays 0, P unchanged, done_o pulses next cycle.
  - A new start issued in the done_o cycle of a prior burst -> accepted, busy_o rises next cycle.
- Reset mid-burst: assert rst at shift 3 of 6 -> P=0, busy_o=0 immediately, no done_o pulse. After release, a LOAD of 0x3C works normally.
